vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
- Generates 640x480@60 Hz VGA raster timing from the 100 MHz board clock.
- Produces the hCount/vCount/bright outputs consumed by the pixel/colour controllers, plus the monitor sync pulses.
- Visible area is hCount 144..783, vCount 35..514, so the top-left pixel is at (144,35).
- Also emits single-cycle pixel, line and frame strobes for downstream logic, e.g. slow position-update clocks.

Parameters:
- CLK_DIV, 4, board clocks per pixel (100 MHz -> 25 MHz); must be >= 2.
- H_TOTAL, 800, clocks per line.
- H_SYNC, 96, hSync low width in pixels, starting at hCount 0.
- H_ACT_START, 144, first visible hCount.
- H_ACT_END, 783, last visible hCount.
- V_TOTAL, 525, lines per frame.
- V_SYNC, 2, vSync low width in lines, starting at vCount 0.
- V_ACT_START, 35, first visible vCount.
- V_ACT_END, 514, last visible vCount.

Ports:
- clk  in  1  board clock.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  run enable; low freezes the raster.
- hCount  out  10  horizontal pixel counter, 0..H_TOTAL-1.
- vCount  out  10  vertical line counter, 0..V_TOTAL-1.
- hSync  out  1  horizontal sync, active low.
- vSync  out  1  vertical sync, active low.
- bright  out  1  high inside the visible area.
- pix_tick  out  1  one-clk strobe coincident with each counter advance.
- line_tick  out  1  one-clk strobe when hCount wraps to 0.
- frame_tick  out  1  one-clk strobe when (hCount,vCount) wraps to (0,0).

Behaviour:
- Reset is asynchronous and active-low. While rst=0: divider=0, hCount=0, vCount=0, hSync=0, vSync=0, bright=0, all ticks=0. Reset mid-frame clears all of these immediately, with no clk edge needed.
- Divider:
  - Runs 0..CLK_DIV-1 and advances only when en=1.
  - An advance occurs on the clk edge where the divider is at CLK_DIV-1; the divider returns to 0 on that same edge.
  - The first advance occurs CLK_DIV enabled edges after reset release.
- Advance rules:
  - hCount==H_TOTAL-1 -> hCount=0 and line_tick=1; otherwise hCount+1.
  - On a line wrap: vCount==V_TOTAL-1 -> vCount=0 and frame_tick=1; otherwise vCount+1.
  - At (H_TOTAL-1, V_TOTAL-1), both counters wrap on one edge, with line_tick and frame_tick both high in the same cycle.
- All outputs are registered. hSync, vSync and bright are decoded from the next-state counter values, so in every cycle they correspond exactly to the hCount/vCount being presented (zero skew, no combinational path to the outputs).
  - hSync = (hCount >= H_SYNC).
  - vSync = (vCount >= V_SYNC).
  - bright = H_ACT_START <= hCount <= H_ACT_END and V_ACT_START <= vCount <= V_ACT_END.
- Tick timing: pix_tick, line_tick and frame_tick are high for exactly the single clk cycle in which the new counter values first appear, and low otherwise.
- en=0:
  - Divider, counters and sync/bright outputs hold.
  - Ticks are forced to 0.
  - Resuming continues from the held divider value; no advance is lost or duplicated.
- Width: counters are 10 bits and compare unsigned. Counters never exceed TOTAL-1; any out-of-range value is treated as a terminal count and wraps to 0.
- Frame period: H_TOTAL*V_TOTAL*CLK_DIV = 1,680,000 clks.

Test Plan:
- Reset: drive rst=0 at (400,300) mid-frame -> within the same cycle all outputs are 0. Release rst -> hCount=1 and pix_tick=1 exactly 4 clks later.
- Cadence: en=1, run 40 clks -> hCount steps 0..10, one step every 4 clks; pix_tick is high 1 cycle in 4.
- Sync/bright line check:
  - hSync=0 for hCount 0..95 and 1 for 96..799.
  - At vCount=35, bright=1 exactly for hCount 144..783.
  - At vCount=34 and vCount=515, bright=0 everywhere.
- Line and frame wrap:
  - (799,10) -> (0,11) with line_tick=1 and frame_tick=0.
  - (799,524) -> (0,0) with line_tick=1 and frame_tick=1 on the same cycle.
  - vSync=0 only for vCount 0..1.
  - Consecutive frame_ticks are 1,680,000 clks apart.
- Enable hold: drop en at hCount=500 with divider=2 for 100 clks -> all outputs are frozen and ticks=0. Raise en -> hCount=501 after 2 clks.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// 640x480@60 Hz VGA raster timing. The board clock is divided down to the
// pixel rate, and the horizontal/vertical counters advance once per pixel
// period. Sync, bright and strobe outputs are all registered and decoded from
// the next-state counter values, so they line up exactly with the counters
// being presented.

module vga_timing_gen #(
  parameter int CLK_DIV     = 4,    // board clocks per pixel, >= 2
  parameter int H_TOTAL     = 800,  // pixels per line
  parameter int H_SYNC      = 96,   // hSync low width, from hCount 0
  parameter int H_ACT_START = 144,  // first visible hCount
  parameter int H_ACT_END   = 783,  // last visible hCount
  parameter int V_TOTAL     = 525,  // lines per frame
  parameter int V_SYNC      = 2,    // vSync low width, from vCount 0
  parameter int V_ACT_START = 35,   // first visible vCount
  parameter int V_ACT_END   = 514   // last visible vCount
) (
  input  logic       clk,
  input  logic       rst,         // asynchronous, active low
  input  logic       en,          // run enable; low freezes the raster
  output logic [9:0] hCount,
  output logic [9:0] vCount,
  output logic       hSync,
  output logic       vSync,
  output logic       bright,
  output logic       pix_tick,
  output logic       line_tick,
  output logic       frame_tick
);

  // Divider width: at least one bit even for the smallest legal divide.
  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  // Terminal and decode constants, sized to the counters they compare with.
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0]       H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0]       V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0]       H_SYNC_C  = 10'(H_SYNC);
  localparam logic [9:0]       V_SYNC_C  = 10'(V_SYNC);
  localparam logic [9:0]       H_ACT_LO  = 10'(H_ACT_START);
  localparam logic [9:0]       H_ACT_HI  = 10'(H_ACT_END);
  localparam logic [9:0]       V_ACT_LO  = 10'(V_ACT_START);
  localparam logic [9:0]       V_ACT_HI  = 10'(V_ACT_END);

  // Inclusive unsigned window test used for the visible-area decode.
  function automatic logic in_window(input logic [9:0] val,
                                     input logic [9:0] lo,
                                     input logic [9:0] hi);
    return (val >= lo) && (val <= hi);
  endfunction

  // Sync is low for the first SYNC counts of the line/frame.
  function automatic logic sync_level(input logic [9:0] val,
                                      input logic [9:0] width);
    return (val >= width);
  endfunction

  // State and output flops.
  logic [DIV_W-1:0] div_q,    div_d;
  logic [9:0]       h_q,      h_d;
  logic [9:0]       v_q,      v_d;
  logic             hsync_q,  hsync_d;
  logic             vsync_q,  vsync_d;
  logic             bright_q, bright_d;
  logic             pix_q,    pix_d;
  logic             line_q,   line_d;
  logic             frame_q,  frame_d;

  // Advance strobe: divider at its terminal count on an enabled edge.
  logic             adv_s;

  // Pixel-rate divider: counts enabled clocks, flags an advance at terminal.
  always_comb begin
    div_d = div_q;
    adv_s = 1'b0;
    if (en) begin
      if (div_q >= DIV_LAST) begin
        // Out-of-range values are treated as terminal so the divider self-heals.
        div_d = {DIV_W{1'b0}};
        adv_s = 1'b1;
      end else begin
        div_d = div_q + {{(DIV_W-1){1'b0}}, 1'b1};
      end
    end else begin
      div_d = div_q;
    end
  end

  // Raster counters and strobes; strobes only ever fire on an advance.
  always_comb begin
    h_d     = h_q;
    v_d     = v_q;
    pix_d   = 1'b0;
    line_d  = 1'b0;
    frame_d = 1'b0;
    if (adv_s) begin
      pix_d = 1'b1;
      if (h_q >= H_LAST) begin
        h_d    = 10'd0;
        line_d = 1'b1;
        if (v_q >= V_LAST) begin
          v_d     = 10'd0;
          frame_d = 1'b1;
        end else begin
          v_d = v_q + 10'd1;
        end
      end else begin
        h_d = h_q + 10'd1;
      end
    end else begin
      h_d = h_q;
      v_d = v_q;
    end
  end

  // Sync/bright decode from the next-state counters for zero skew.
  always_comb begin
    hsync_d  = sync_level(h_d, H_SYNC_C);
    vsync_d  = sync_level(v_d, V_SYNC_C);
    bright_d = in_window(h_d, H_ACT_LO, H_ACT_HI) &&
               in_window(v_d, V_ACT_LO, V_ACT_HI);
  end

  // State register with asynchronous active-low clear of every output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q    <= {DIV_W{1'b0}};
      h_q      <= 10'd0;
      v_q      <= 10'd0;
      hsync_q  <= 1'b0;
      vsync_q  <= 1'b0;
      bright_q <= 1'b0;
      pix_q    <= 1'b0;
      line_q   <= 1'b0;
      frame_q  <= 1'b0;
    end else begin
      div_q    <= div_d;
      h_q      <= h_d;
      v_q      <= v_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      bright_q <= bright_d;
      pix_q    <= pix_d;
      line_q   <= line_d;
      frame_q  <= frame_d;
    end
  end

  assign hCount     = h_q;
  assign vCount     = v_q;
  assign hSync      = hsync_q;
  assign vSync      = vsync_q;
  assign bright     = bright_q;
  assign pix_tick   = pix_q;
  assign line_tick  = line_q;
  assign frame_tick = frame_q;

endmodule
